// File: rtl/sram_arb_pkg.sv
// Shared state encoding, default widths and strobe helpers for the SRAM arbiter.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_TURN
  } arb_state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = 5'b11111;

  // Strobe pattern the pads must present while the FSM sits in state st.
  function automatic strobe_t strobes_for(arb_state_t st, logic [1:0] be);
    strobe_t s;
    s = STROBE_IDLE;
    case (st)
      ST_RD:   s = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, ub_n: 1'b0, lb_n: 1'b0};
      ST_WR:   s = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, ub_n: ~be[1], lb_n: ~be[0]};
      default: s = STROBE_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle: one writer and one display reader.
interface sram_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_be;
  logic              wr_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr,
    input  wr_gnt, rd_gnt, rd_data, rd_valid
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr,
    output wr_gnt, rd_gnt, rd_data, rd_valid
  );

endinterface

// File: rtl/sram_pad_io.sv
// SRAM pad registers: address/strobe outputs, write-data hold, tristate data bus
// and read-data capture.
module sram_pad_io
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  arb_state_t        state,
  input  arb_state_t        next_state,
  input  logic              rd_gnt,
  input  logic              wr_gnt,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              ce_n,
  output logic              oe_n,
  output logic              we_n,
  output logic              ub_n,
  output logic              lb_n,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  strobe_t           strobes;
  logic              dq_oe;
  logic [DATA_W-1:0] wr_data_q;

  // Strobes and the bus enable both derive from next_state, so the data bus
  // can never be driven in a cycle where oe_n is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobes   <= STROBE_IDLE;
      dq_oe     <= 1'b0;
      sram_addr <= '0;
      wr_data_q <= '0;
    end else begin
      strobes <= strobes_for(next_state, wr_be);
      dq_oe   <= (next_state == ST_WR);
      if (rd_gnt) begin
        sram_addr <= rd_addr;
      end else if (wr_gnt) begin
        sram_addr <= wr_addr;
        wr_data_q <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (state == ST_RD);
      if (state == ST_RD) begin
        rd_data <= sram_dq;
      end
    end
  end

  assign {ce_n, oe_n, we_n, ub_n, lb_n} = strobes;
  assign sram_dq = dq_oe ? wr_data_q : {DATA_W{1'bz}};

endmodule

// File: rtl/sram_arbiter.sv
// Single-port async SRAM arbiter, read-priority with one-cycle bus turnaround.
// Optional write-starvation guard enabled by defining SRAM_ARB_STARVE_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_RD_RUN = 16
) (
  input  logic              clk,
  input  logic              rst,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              ce_n,
  output logic              oe_n,
  output logic              we_n,
  output logic              ub_n,
  output logic              lb_n
);

  arb_state_t state;
  arb_state_t next_state;
  logic       favor_wr;
  logic       rd_win;
  logic       wr_win;
  logic       rd_gnt;
  logic       wr_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  assign rd_win = bus.rd_req && !(favor_wr && bus.wr_req);
  assign wr_win = bus.wr_req && !rd_win;

  // A direction change from RD/WR always detours through TURN.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE, ST_TURN: begin
        if (rd_win)      next_state = ST_RD;
        else if (wr_win) next_state = ST_WR;
      end
      ST_RD: begin
        if (rd_win)      next_state = ST_RD;
        else if (wr_win) next_state = ST_TURN;
      end
      ST_WR: begin
        if (wr_win)      next_state = ST_WR;
        else if (rd_win) next_state = ST_TURN;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (rst) begin
      rd_gnt = (next_state == ST_RD);
      wr_gnt = (next_state == ST_WR);
    end
  end

  assign bus.rd_gnt = rd_gnt;
  assign bus.wr_gnt = wr_gnt;

`ifdef SRAM_ARB_STARVE_EN
  localparam int RUN_W = $clog2(MAX_RD_RUN + 1);
  logic [RUN_W-1:0] rd_run;

  // Counts reads granted past a waiting writer; saturates until the write wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_run <= '0;
    end else if (wr_gnt || !bus.wr_req) begin
      rd_run <= '0;
    end else if (rd_gnt && (rd_run != RUN_W'(MAX_RD_RUN))) begin
      rd_run <= rd_run + 1'b1;
    end
  end

  assign favor_wr = (rd_run == RUN_W'(MAX_RD_RUN));
`else
  logic unused_run_limit;
  assign unused_run_limit = ^MAX_RD_RUN;
  assign favor_wr = 1'b0;
`endif

  sram_pad_io #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_pad (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .next_state(next_state),
    .rd_gnt    (rd_gnt),
    .wr_gnt    (wr_gnt),
    .rd_addr   (bus.rd_addr),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .wr_be     (bus.wr_be),
    .sram_addr (sram_addr),
    .ce_n      (ce_n),
    .oe_n      (oe_n),
    .we_n      (we_n),
    .ub_n      (ub_n),
    .lb_n      (lb_n),
    .sram_dq   (sram_dq),
    .rd_data   (bus.rd_data),
    .rd_valid  (bus.rd_valid)
  );

endmodule
